// File: rtl/control_sequencer.sv
// control_sequencer: falling-edge T-state control sequencer with variable-length instructions and a HALT trap.
// Build option: define CTRL_SEQ_COND_JMP_EN to decode JC(8)/JZ(9); otherwise they behave as NOP.
module control_sequencer #(
  parameter int          OP_W      = 4,
  parameter logic [14:0] IDLE_WORD = 15'h0FE3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            step_en,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic [14:0]     ctrl,
  output logic [2:0]      stage,
  output logic            halted,
  output logic            instr_done
);

  localparam logic [2:0] T0   = 3'd0;
  localparam logic [2:0] T1   = 3'd1;
  localparam logic [2:0] T2   = 3'd2;
  localparam logic [2:0] T3   = 3'd3;
  localparam logic [2:0] T4   = 3'd4;
  localparam logic [2:0] T5   = 3'd5;
  localparam logic [2:0] HOLD = 3'd6;
  localparam logic [2:0] HALT = 3'd7;

  // Strobe masks: XOR with IDLE_WORD asserts a strobe whatever its polarity.
  localparam logic [14:0] M_CP  = 15'h4000;
  localparam logic [14:0] M_EP  = 15'h2000;
  localparam logic [14:0] M_LP  = 15'h1000;
  localparam logic [14:0] M_LMA = 15'h0800;
  localparam logic [14:0] M_LMD = 15'h0400;
  localparam logic [14:0] M_CE  = 15'h0200;
  localparam logic [14:0] M_LR  = 15'h0100;
  localparam logic [14:0] M_LI  = 15'h0080;
  localparam logic [14:0] M_EI  = 15'h0040;
  localparam logic [14:0] M_LA  = 15'h0020;
  localparam logic [14:0] M_EA  = 15'h0010;
  localparam logic [14:0] M_SU  = 15'h0008;
  localparam logic [14:0] M_EU  = 15'h0004;
  localparam logic [14:0] M_LB  = 15'h0002;
  localparam logic [14:0] M_LO  = 15'h0001;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_NOP = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_LDA = 4'd4;
  localparam logic [3:0] OP_OUT = 4'd5;
  localparam logic [3:0] OP_STA = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JC  = 4'd8;
  localparam logic [3:0] OP_JZ  = 4'd9;

  logic [2:0]  state;
  logic [7:0]  op_ext;
  logic [3:0]  op;
  logic        long_op;
  logic [14:0] nxt_mask;
  logic [2:0]  nxt_state;
  logic        nxt_done;
  logic        go_halt;

  assign op_ext = 8'(opcode);
  assign op     = (op_ext[7:4] != 4'd0) ? OP_NOP : op_ext[3:0];

`ifndef CTRL_SEQ_COND_JMP_EN
  logic unused_flags;
  assign unused_flags = flag_c ^ flag_z;
`endif

  // Opcodes that continue past T2; everything else ends the fetch as a NOP.
  always_comb begin
    long_op = 1'b0;
    case (op)
      OP_HLT, OP_ADD, OP_SUB, OP_LDA, OP_OUT, OP_STA, OP_JMP: long_op = 1'b1;
`ifdef CTRL_SEQ_COND_JMP_EN
      OP_JC, OP_JZ: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  always_comb begin
    nxt_mask  = '0;
    nxt_state = T0;
    nxt_done  = 1'b0;
    go_halt   = 1'b0;
    case (state)
      T0: begin
        nxt_mask  = M_EP | M_LMA;
        nxt_state = T1;
      end
      T1: begin
        nxt_mask  = M_CP;
        nxt_state = T2;
      end
      T2: begin
        nxt_mask  = M_CE | M_LI;
        nxt_state = long_op ? T3 : T0;
        nxt_done  = !long_op;
      end
      T3: begin
        nxt_done = 1'b1;
        case (op)
          OP_HLT: begin
            go_halt   = 1'b1;
            nxt_state = HALT;
            nxt_done  = 1'b0;
          end
          OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
            nxt_mask  = M_EI | M_LMA;
            nxt_state = T4;
            nxt_done  = 1'b0;
          end
          OP_OUT: nxt_mask = M_EA | M_LO;
          OP_JMP: nxt_mask = M_EI | M_LP;
`ifdef CTRL_SEQ_COND_JMP_EN
          OP_JC: nxt_mask = flag_c ? (M_EI | M_LP) : '0;
          OP_JZ: nxt_mask = flag_z ? (M_EI | M_LP) : '0;
`endif
          default: nxt_mask = '0;
        endcase
      end
      T4: begin
        nxt_done = 1'b1;
        case (op)
          OP_ADD, OP_SUB: begin
            nxt_mask  = M_CE | M_LB;
            nxt_state = T5;
            nxt_done  = 1'b0;
          end
          OP_LDA: nxt_mask = M_CE | M_LA;
          OP_STA: begin
            nxt_mask  = M_EA | M_LMD;
            nxt_state = T5;
            nxt_done  = 1'b0;
          end
          default: nxt_mask = '0;
        endcase
      end
      T5: begin
        nxt_done = 1'b1;
        case (op)
          OP_ADD:  nxt_mask = M_EU | M_LA;
          OP_SUB:  nxt_mask = M_EU | M_SU | M_LA;
          OP_STA:  nxt_mask = M_LR;
          default: nxt_mask = '0;
        endcase
      end
      HOLD:    nxt_state = T0;
      default: nxt_state = HALT;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state      <= HOLD;
      stage      <= HOLD;
      ctrl       <= IDLE_WORD;
      halted     <= 1'b0;
      instr_done <= 1'b0;
    end else if (state == HALT) begin
      stage      <= HALT;
      ctrl       <= IDLE_WORD;
      halted     <= 1'b1;
      instr_done <= 1'b0;
    end else if (step_en) begin
      state      <= nxt_state;
      stage      <= go_halt ? HALT : state;
      ctrl       <= IDLE_WORD ^ nxt_mask;
      halted     <= go_halt;
      instr_done <= nxt_done;
    end else begin
      // Frozen: state and stage hold, strobes drop so nothing fires twice.
      ctrl       <= IDLE_WORD;
      instr_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; outputs sampled 1 time unit after each falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        step_en;
  logic        flag_c;
  logic        flag_z;
  logic [14:0] ctrl;
  logic [2:0]  stage;
  logic        halted;
  logic        instr_done;

  int checks = 0;
  int errors = 0;
  logic [19:0] q[$];

  always #5 clk = ~clk;

  control_sequencer #(.OP_W(4), .IDLE_WORD(15'h0FE3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_en(step_en),
    .flag_c(flag_c), .flag_z(flag_z), .ctrl(ctrl), .stage(stage),
    .halted(halted), .instr_done(instr_done)
  );

  function automatic logic [19:0] e(input logic [14:0] c, input logic [2:0] s,
                                    input logic d, input logic h);
    return {c, s, d, h};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_en = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step_en = 1'b0; opcode = 4'd3; flag_c = 1'b0; flag_z = 1'b0;
    tick();
    checks++;
    if ({ctrl, stage, instr_done, halted} !== e(15'h0FE3, 3'd6, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset: ctrl=%h stage=%0d done=%b halted=%b, want 0fe3/6/0/0",
               ctrl, stage, instr_done, halted);
    end
    // Abort mid-instruction at T4, then release and restart.
    rst_n = 1'b1; step_en = 1'b1;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0)};
    rst_n = 1'b0;
    foreach (q[i]) begin
      if (i == 1) rst_n = 1'b1;
      if (i > 0) tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL reset_mid step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  task automatic test_nop();
    do_reset();
    opcode = 4'd1;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      if (i == 4) opcode = 4'hC;
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL nop step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
    // Unused opcode 12 behaves as NOP.
    q = '{e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL unused_op step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    opcode = 4'd3;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 0, 0), e(15'h07A3, 3'd3, 0, 0), e(15'h0DE1, 3'd4, 0, 0),
          e(15'h0FCF, 3'd5, 1, 0), e(15'h27E3, 3'd0, 0, 0),
          e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 0, 0), e(15'h07A3, 3'd3, 0, 0),
          e(15'h0DE1, 3'd4, 0, 0), e(15'h0FC7, 3'd5, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      if (i == 8) opcode = 4'd2;
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL sub_add step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  task automatic test_sta_lda();
    do_reset();
    opcode = 4'd6;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 0, 0), e(15'h07A3, 3'd3, 0, 0), e(15'h0BF3, 3'd4, 0, 0),
          e(15'h0EE3, 3'd5, 1, 0), e(15'h27E3, 3'd0, 0, 0),
          e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 0, 0), e(15'h07A3, 3'd3, 0, 0),
          e(15'h0DC3, 3'd4, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      if (i == 8) opcode = 4'd4;
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL sta_lda step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  task automatic test_out_jmp();
    do_reset();
    opcode = 4'd5;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 0, 0), e(15'h0FF2, 3'd3, 1, 0), e(15'h27E3, 3'd0, 0, 0),
          e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 0, 0), e(15'h1FA3, 3'd3, 1, 0),
          e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      if (i == 6) opcode = 4'd7;
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL out_jmp step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    opcode = 4'd1;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h0FE3, 3'd0, 0, 0),
          e(15'h0FE3, 3'd0, 0, 0), e(15'h0FE3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
    foreach (q[i]) begin
      step_en = !(i >= 2 && i <= 4);
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL freeze step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
    step_en = 1'b1;
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'd0;
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 0, 0), e(15'h0FE3, 3'd7, 0, 1)};
    foreach (q[i]) begin
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL halt_entry step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step_en = i[0];
      opcode = i[3:0];
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== e(15'h0FE3, 3'd7, 0, 1)) begin
        errors++;
        $display("FAIL halt_hold edge %0d: ctrl=%h stage=%0d done=%b halted=%b, want 0fe3/7/0/1",
                 i, ctrl, stage, instr_done, halted);
      end
    end
    rst_n = 1'b0;
    step_en = 1'b1;
    tick();
    checks++;
    if ({ctrl, stage, instr_done, halted} !== e(15'h0FE3, 3'd6, 0, 0)) begin
      errors++;
      $display("FAIL halt_reset: ctrl=%h stage=%0d done=%b halted=%b, want 0fe3/6/0/0",
               ctrl, stage, instr_done, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cond_jmp();
    do_reset();
    opcode = 4'd9;
    flag_z = 1'b1;
    flag_c = 1'b0;
`ifdef CTRL_SEQ_COND_JMP_EN
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 0, 0), e(15'h1FA3, 3'd3, 1, 0), e(15'h27E3, 3'd0, 0, 0),
          e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 0, 0), e(15'h0FE3, 3'd3, 1, 0),
          e(15'h27E3, 3'd0, 0, 0)};
`else
    q = '{e(15'h0FE3, 3'd6, 0, 0), e(15'h27E3, 3'd0, 0, 0), e(15'h4FE3, 3'd1, 0, 0),
          e(15'h0D63, 3'd2, 1, 0), e(15'h27E3, 3'd0, 0, 0),
          e(15'h4FE3, 3'd1, 0, 0), e(15'h0D63, 3'd2, 1, 0), e(15'h27E3, 3'd0, 0, 0)};
`endif
    foreach (q[i]) begin
      if (i == 5) flag_z = 1'b0;
      tick();
      checks++;
      if ({ctrl, stage, instr_done, halted} !== q[i]) begin
        errors++;
        $display("FAIL cond_jz step %0d: ctrl=%h stage=%0d done=%b halted=%b, want %h/%0d/%b/%b",
                 i, ctrl, stage, instr_done, halted, q[i][19:5], q[i][4:2], q[i][1], q[i][0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_back_to_back();
    test_sta_lda();
    test_out_jmp();
    test_freeze();
    test_halt();
    test_cond_jmp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, giving the opcode width, legal range 4..8.
REQ-002 The block SHALL have parameter IDLE_WORD, default 15'h0FE3, giving the deasserted control word (active-low strobes high, active-high strobes low).
REQ-003 The block SHALL have port clk  input  1  sequencer clock; all state changes occur on the falling edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port opcode  input  OP_W  instruction register opcode field.
REQ-006 The block SHALL have port step_en  input  1  advance enable; low freezes sequencing (single-step support).
REQ-007 The block SHALL have port flag_c  input  1  ALU carry flag.
REQ-008 The block SHALL have port flag_z  input  1  ALU zero flag.
REQ-009 The block SHALL have port ctrl  output  15  registered control word, bit map 14 C_P, 13 E_P, 12 L_P, 11 /L_MA, 10 /L_MD, 9 /CE, 8 /L_R, 7 /L_I, 6 /E_I, 5 /L_A, 4 E_A, 3 S_U, 2 E_U, 1 /L_B, 0 /L_O.
REQ-010 The block SHALL have port stage  output  3  T-state currently driving ctrl: 0..5 = T0..T5, 6 = HOLD, 7 = HALT.
REQ-011 The block SHALL have port halted  output  1  high while in HALT.
REQ-012 The block SHALL have port instr_done  output  1  one-edge pulse, high while ctrl carries the final step of an instruction.

Function
REQ-013 On each falling edge with step_en=1, ctrl SHALL load the word for (current state, opcode) and the state SHALL advance; stage output SHALL equal the state whose word is on ctrl.
REQ-014 With step_en=0, state SHALL hold and ctrl SHALL load IDLE_WORD, so no strobe repeats while frozen.
REQ-015 Fetch, all opcodes: T0 E_P,/L_MA; T1 C_P; T2 /CE,/L_I; the opcode is decoded from T3 onward.
REQ-016 Each instruction SHALL execute only its own steps (variable length); the state after its last step SHALL be T0, with no idle T-states.
REQ-017 ADD(2): T3 /E_I,/L_MA; T4 /CE,/L_B; T5 E_U,/L_A; 6 steps.
REQ-018 SUB(3): as ADD, plus S_U in T5; 6 steps.
REQ-019 LDA(4): T3 /E_I,/L_MA; T4 /CE,/L_A; 5 steps.
REQ-020 STA(6): T3 /E_I,/L_MA; T4 E_A,/L_MD; T5 /L_R; 6 steps.
REQ-021 OUT(5): T3 E_A,/L_O; 4 steps.
REQ-022 JMP(7): T3 /E_I,L_P; 4 steps.
REQ-023 NOP(1), unused opcodes, and any opcode with nonzero bits above bit 3 SHALL decode as NOP: 3 steps, with the next state after T2 being T0.
REQ-024 HLT(0): T3 SHALL enter HALT with ctrl=IDLE_WORD; HALT SHALL be held until reset, regardless of opcode and step_en; halted=1.
REQ-025 instr_done SHALL accompany T2 for NOP, T3 for OUT/JMP/JC/JZ, T4 for LDA, and T5 for ADD/SUB/STA; it SHALL never be asserted in HOLD or HALT.
REQ-026 opcode and flags SHALL be sampled at every decode edge; a change mid-instruction affects only the remaining steps.

Reset
REQ-027 When rst_n=0 at a falling edge: state=HOLD, ctrl=IDLE_WORD, halted=0, instr_done=0, irrespective of step_en.
REQ-028 The first enabled edge after release SHALL go HOLD->T0 with ctrl=IDLE_WORD; the T0 word SHALL appear on the following enabled edge.
REQ-029 Reset mid-instruction or in HALT SHALL abort immediately, with no partial strobes.

Configuration
REQ-030 Macro CTRL_SEQ_COND_JMP_EN defined: JC(8) and JZ(9) are decoded; if taken (flag_c=1 / flag_z=1 at the T3 edge), T3 = /E_I,L_P; if not taken, T3 = IDLE_WORD; both take 4 steps.
REQ-031 Macro CTRL_SEQ_COND_JMP_EN undefined: opcodes 8 and 9 decode as NOP, and flag_c and flag_z are unused.

Verification
REQ-032 Reset then 4 enabled edges, opcode=1 -> ctrl: 0FE3 (HOLD), 27E3 (T0), 4FE3 (T1), 0D63 (T2, instr_done=1); next edge T0.
REQ-033 opcode=3 for a full instruction -> T5 ctrl=0FCF, instr_done=1; next stage=0.
REQ-034 opcode=6 -> T4 ctrl=0BF3, T5 ctrl=0EE3; opcode=4 -> instruction ends at T4 with ctrl=0DC3.
REQ-035 opcode=0 -> at T3 halted=1, stage=7, ctrl=0FE3 held for 20 edges with step_en toggling; rst_n=0 -> stage=6.
REQ-036 With macro: opcode=9, flag_z=1 -> T3 ctrl=1FA3; with flag_z=0 -> T3 ctrl=0FE3; without macro, opcode=9 -> ends after T2.
REQ-037 step_en=0 for 3 edges after T0 -> stage stays 0, ctrl=0FE3; re-enable -> T1 C_P issued exactly once.
